// File: rtl/cpu_ctrl.sv
// cpu_ctrl: eight-step instruction sequencer issuing fetch/execute control strobes; optional halt latch via CTRL_HALT_LATCH_EN.
// Latency: strobes are registered and valid during the cycle the FSM sits in the step they belong to; fetch starts ST0 one edge later.
// Backpressure: none; the sequence free-runs once started and only reset can stop it (or hold it in HALTED).
module cpu_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt,
  output logic [2:0] state
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST0,
    S_ST1,
    S_ST2,
    S_ST3,
    S_ST4,
    S_ST5,
    S_ST6,
    S_ST7
`ifdef CTRL_HALT_LATCH_EN
    , S_HALTED
`endif
  } state_e;

  // All strobes travel together so they share one register.
  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  logic op_alu, op_sto, op_jmp, op_skz, op_hlt;

  assign op_alu = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                  (opcode == OP_XORR) || (opcode == OP_LDA);
  assign op_sto = (opcode == OP_STO);
  assign op_jmp = (opcode == OP_JMP);
  assign op_skz = (opcode == OP_SKZ);
  assign op_hlt = (opcode == OP_HLT);

  // Next step: fetch only matters in IDLE; the cycle wraps ST7 -> ST0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch) state_d = S_ST0;
      S_ST0:   state_d = S_ST1;
      S_ST1:   state_d = S_ST2;
      S_ST2:   state_d = S_ST3;
`ifdef CTRL_HALT_LATCH_EN
      S_ST3:   state_d = op_hlt ? S_HALTED : S_ST4;
      S_HALTED: state_d = S_HALTED;
`else
      S_ST3:   state_d = S_ST4;
`endif
      S_ST4:   state_d = S_ST5;
      S_ST5:   state_d = S_ST6;
      S_ST6:   state_d = S_ST7;
      S_ST7:   state_d = S_ST0;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes for the step being entered, so the registered value lines up with that step.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_ST0, S_ST1: begin
        ctrl_d.rd      = 1'b1;
        ctrl_d.load_ir = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
      end
      S_ST3: ctrl_d.halt = op_hlt;
      S_ST4: begin
        ctrl_d.rd          = op_alu;
        ctrl_d.datactl_ena = op_sto;
        ctrl_d.load_pc     = op_jmp;
        ctrl_d.inc_pc      = op_jmp;
      end
      S_ST5: begin
        ctrl_d.rd          = op_alu;
        ctrl_d.load_acc    = op_alu;
        ctrl_d.wr          = op_sto;
        ctrl_d.datactl_ena = op_sto;
        ctrl_d.inc_pc      = op_skz & zero;
      end
      S_ST6: begin
        ctrl_d.rd          = op_alu;
        ctrl_d.datactl_ena = op_sto;
      end
      S_ST7: ctrl_d.inc_pc = op_skz & zero;
`ifdef CTRL_HALT_LATCH_EN
      S_HALTED: ctrl_d.halt = 1'b1;
`endif
      default: ctrl_d = '0;
    endcase
  end

  // State and strobe registers; reset drops everything immediately, clock or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Debug step number: IDLE reads 0, HALTED reads 3 (the step that stopped it).
  always_comb begin
    state = 3'd0;
    case (state_q)
      S_ST0:    state = 3'd0;
      S_ST1:    state = 3'd1;
      S_ST2:    state = 3'd2;
      S_ST3:    state = 3'd3;
      S_ST4:    state = 3'd4;
      S_ST5:    state = 3'd5;
      S_ST6:    state = 3'd6;
      S_ST7:    state = 3'd7;
`ifdef CTRL_HALT_LATCH_EN
      S_HALTED: state = 3'd3;
`endif
      default:  state = 3'd0;
    endcase
  end

  assign inc_pc      = ctrl_q.inc_pc;
  assign load_acc    = ctrl_q.load_acc;
  assign load_pc     = ctrl_q.load_pc;
  assign rd          = ctrl_q.rd;
  assign wr          = ctrl_q.wr;
  assign load_ir     = ctrl_q.load_ir;
  assign datactl_ena = ctrl_q.datactl_ena;
  assign halt        = ctrl_q.halt;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed and randomized checks of cpu_ctrl against a step-counter model.
// Latency: model advances on each rising edge; comparisons happen on the falling edge.
// Backpressure: not applicable.
module tb_cpu_ctrl;

  logic       clk = 1'b0;
  logic       reset, fetch, zero;
  logic [2:0] opcode;
  logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;
  logic [2:0] state;

  cpu_ctrl dut (
    .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
    .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt), .state(state)
  );

  always #5 clk = ~clk;

`ifdef CTRL_HALT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  // Strobe vector order: inc_pc load_acc load_pc rd wr load_ir datactl_ena halt
  logic [7:0] dv;
  assign dv = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, got, exp);
    end
  endtask

  // Reference: which strobes the step table demands for a given step/opcode/zero.
  function automatic logic [7:0] expect_fn(input int step, input logic [2:0] op, input logic z);
    bit alu, sto, jmp, skz, hlt;
    logic i_pc, l_acc, l_pc, r, w, l_ir, de, h;
    alu = (op >= 3'd2) && (op <= 3'd5);
    sto = (op == 3'd6);
    jmp = (op == 3'd7);
    skz = (op == 3'd1);
    hlt = (op == 3'd0);
    {i_pc, l_acc, l_pc, r, w, l_ir, de, h} = 8'h00;
    if (step == 0 || step == 1) begin
      r = 1; l_ir = 1; i_pc = 1;
    end else if (step == 3) begin
      h = hlt;
    end else if (step == 4) begin
      r = alu; de = sto; l_pc = jmp; i_pc = jmp;
    end else if (step == 5) begin
      r = alu; l_acc = alu; w = sto; de = sto; i_pc = skz & z;
    end else if (step == 6) begin
      r = alu; de = sto;
    end else if (step == 7) begin
      i_pc = skz & z;
    end
    return {i_pc, l_acc, l_pc, r, w, l_ir, de, h};
  endfunction

  // Model: step -1 is idle, otherwise 0..7; halted is a separate sticky flag.
  int         m_step   = -1;
  bit         m_halted = 1'b0;
  logic [7:0] exp_vec  = 8'h00;
  logic [7:0] exp_state;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_step   = -1;
      m_halted = 1'b0;
      exp_vec  = 8'h00;
    end else begin
      if (m_halted) begin
        m_step = m_step;
      end else if (m_step < 0) begin
        if (fetch) m_step = 0;
      end else if (m_step == 3 && opcode == 3'd0 && LATCH) begin
        m_halted = 1'b1;
      end else begin
        m_step = (m_step + 1) % 8;
      end
      exp_vec = m_halted ? 8'h01 : expect_fn(m_step, opcode, zero);
    end
  end

  assign exp_state = m_halted ? 8'd3 : (m_step < 0 ? 8'd0 : 8'(m_step));

  // Cycle-by-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_strobes", dv, exp_vec);
      chk("model_state", {5'b0, state}, exp_state);
      chk("rd_wr_exclusive", {7'b0, rd & wr}, 8'h00);
    end
  end

  // Run n steps of one instruction, checking each step against a literal table (ST0 first, MSB byte).
  task automatic runn(input logic [2:0] op, input logic z, input logic [63:0] tbl, input int n);
    opcode = op;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("lit_state", {5'b0, state}, 8'(i));
      chk("lit_strobes", dv, tbl[63-8*i -: 8]);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit found;
    int hc;
    reset = 1'b1; fetch = 1'b0; opcode = 3'd0; zero = 1'b0;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {5'b0, state}, 8'h00);
    chk("reset_strobes", dv, 8'h00);
    reset = 1'b1;

    // Idle with fetch low: nothing moves.
    repeat (5) begin
      @(negedge clk);
      chk("idle_state", {5'b0, state}, 8'h00);
      chk("idle_strobes", dv, 8'h00);
    end
    fetch = 1'b1;

    runn(3'd2, 1'b0, 64'h9494_0000_1050_1000, 8);   // ADD
    runn(3'd6, 1'b0, 64'h9494_0000_020A_0200, 8);   // STO
    runn(3'd7, 1'b0, 64'h9494_0000_A000_0000, 8);   // JMP
    runn(3'd1, 1'b1, 64'h9494_0000_0080_0080, 8);   // SKZ, zero=1
    runn(3'd1, 1'b0, 64'h9494_0000_0000_0000, 8);   // SKZ, zero=0
    if (LATCH) begin
      runn(3'd0, 1'b0, 64'h9494_0001_0000_0000, 4); // HLT enters HALTED
      repeat (20) begin
        @(negedge clk);
        chk("halted_state", {5'b0, state}, 8'h03);
        chk("halted_strobes", dv, 8'h01);
      end
    end else begin
      runn(3'd0, 1'b0, 64'h9494_0001_0000_0000, 8); // HLT one-cycle pulse
      @(negedge clk);
      chk("hlt_wrap_state", {5'b0, state}, 8'h00);
      chk("hlt_wrap_strobes", dv, 8'h94);
    end

    // LDA aborted asynchronously in ST5.
    pulse_reset();
    fetch  = 1'b1;
    opcode = 3'd5;
    found  = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (state == 3'd5 && m_step == 5) found = 1'b1;
    end
    chk("lda_reach_st5", {7'b0, found}, 8'h01);
    chk("lda_st5_strobes", dv, 8'h50);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_strobes", dv, 8'h00);
    chk("async_reset_state", {5'b0, state}, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    fetch = 1'b1;
    @(negedge clk);
    chk("restart_state", {5'b0, state}, 8'h00);
    chk("restart_strobes", dv, 8'h94);

    // Random traffic; opcode/zero only change while the next edges don't consume them.
    hc = 0;
    repeat (3000) begin
      @(negedge clk);
      if (!m_halted && m_step <= 1) begin
        opcode = 3'($urandom_range(0, 7));
        zero   = 1'($urandom_range(0, 1));
      end
      fetch = ($urandom_range(0, 3) != 0);
      if (m_halted) hc++;
      else hc = 0;
      if (hc > 20 || $urandom_range(0, 149) == 0) begin
        pulse_reset();
        hc = 0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
